display_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit seven-segment driver for the vending front panel.
- Latches a binary value and a display mode, converts the value to BCD sequentially (shift-add-3, one bit per cycle), and scans digits onto shared segment lines with one-hot anode select.
- Adds leading-zero suppression, overflow indication, blink, and a pending-load slot, none of which the fixed 4-digit combinational display path provides.

---
 rtl/display_scan_if.sv | 17 +
 rtl/display_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_display_scan_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// display_scan_if: value/mode request and scanned segment/anode drive for the front-panel display.
interface display_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 8
);
   logic [VALUE_W-1:0]    value;
   logic [1:0]            mode;
   logic                  load;
   logic                  blink_en;
   logic [6:0]            seg;
   logic [NUM_DIGITS-1:0] an;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   modport master (output value, mode, load, blink_en, input seg, an, busy, done, overflow);
   modport slave  (input value, mode, load, blink_en, output seg, an, busy, done, overflow);
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: sequential binary-to-BCD conversion feeding a multiplexed N-digit seven-segment scan.
module display_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int VALUE_W        = 8,
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_DIV      = 25000000,
   parameter bit SEG_ACTIVE_LOW = 1,
   parameter bit AN_ACTIVE_LOW  = 1
) (
   input logic           clk,
   input logic           rst,
   display_scan_if.slave dsp_io
);
   localparam int BW = 4 * NUM_DIGITS;
   localparam int DW = 7 * NUM_DIGITS;
   localparam int CW = $clog2(VALUE_W + 1);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int KW = $clog2(BLINK_DIV + 1);
   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
   localparam logic [111:0] SEG_LUT = {42'd0, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                       7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
   localparam logic [27:0] MSG_ERR  = {7'h79, 7'h50, 7'h50, 7'h00};
   localparam logic [27:0] MSG_DONE = {7'h5E, 7'h5C, 7'h54, 7'h79};

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t                     state_q, state_d;
   logic [VALUE_W-1:0]         val_q, val_d, pval_q, pval_d;
   logic [1:0]                 mode_q, mode_d, pmode_q, pmode_d;
   logic [BW-1:0]              bcd_q, bcd_d, adj;
   logic                       ovf_q, ovf_d, pv_q, pv_d, done_q, done_d, oflo_q, oflo_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][6:0] disp_q, disp_d, pat;
   logic [SW-1:0]              sc_q, sc_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [KW-1:0]              bk_q, bk_d;
   logic                       ph_q, ph_d, dark, nz;
   logic [6:0]                 seg_q, seg_d, num;
   logic [NUM_DIGITS-1:0]      an_q, an_d;
   logic [3:0]                 nib;
   logic [DW-1:0]              msg_all;

   // Content each digit will show once the current conversion commits
   always_comb begin
      adj = bcd_q;
      nz = 1'b0;
      nib = 4'd0;
      num = 7'h00;
      pat = '0;
      msg_all = DW'(mode_q == 2'd1 ? MSG_ERR : MSG_DONE) << (7 * (NUM_DIGITS - 4));
      for (int i = 0; i < NUM_DIGITS; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] + (bcd_q[4*i +: 4] >= 4'd5 ? 4'd3 : 4'd0);
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nib = bcd_q[4*i +: 4];
         nz = nz | (nib != 4'd0) | (i == 0);
         num = ovf_q ? 7'h40 : nz ? SEG_LUT[7*nib +: 7] : 7'h00;
         pat[i] = mode_q == 2'd0 ? num : mode_q == 2'd3 ? 7'h00 : msg_all[7*i +: 7];
      end
   end

   always_comb begin
      state_d = state_q;
      val_d = val_q;
      mode_d = mode_q;
      bcd_d = bcd_q;
      ovf_d = ovf_q;
      cnt_d = cnt_q;
      pv_d = pv_q;
      pval_d = pval_q;
      pmode_d = pmode_q;
      disp_d = disp_q;
      done_d = 1'b0;
      oflo_d = oflo_q;
      if (dsp_io.load && state_q != IDLE) begin
         pval_d = dsp_io.value;
         pmode_d = dsp_io.mode;
      end
      case (state_q)
         IDLE: if (dsp_io.load) begin
            val_d = dsp_io.value;
            mode_d = dsp_io.mode;
            bcd_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
            state_d = CONV;
         end
         CONV: begin
            bcd_d = {adj[BW-2:0], val_q[VALUE_W-1]};
            ovf_d = ovf_q | adj[BW-1];
            val_d = val_q << 1;
            cnt_d = cnt_q + CW'(1);
            pv_d = pv_q | dsp_io.load;
            state_d = cnt_q == CW'(VALUE_W - 1) ? COMMIT : CONV;
         end
         COMMIT: begin
            disp_d = pat;
            done_d = 1'b1;
            oflo_d = ovf_q && mode_q == 2'd0;
            // A fresh load with an empty slot starts directly; a full slot is consumed and refilled by it
            val_d = pv_q ? pval_q : dsp_io.value;
            mode_d = pv_q ? pmode_q : dsp_io.mode;
            pv_d = pv_q && dsp_io.load;
            bcd_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
            state_d = pv_q || dsp_io.load ? CONV : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sc_d = sc_q == SW'(SCAN_DIV - 1) ? '0 : sc_q + SW'(1);
      idx_d = sc_q != SW'(SCAN_DIV - 1) ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
      bk_d = bk_q == KW'(BLINK_DIV - 1) ? '0 : bk_q + KW'(1);
      ph_d = bk_q == KW'(BLINK_DIV - 1) ? ~ph_q : ph_q;
      dark = dsp_io.blink_en && !ph_q;
      seg_d = dark ? SEG_OFF : disp_q[idx_q] ^ SEG_OFF;
      an_d = dark ? AN_OFF : (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         val_q <= '0;
         mode_q <= '0;
         pval_q <= '0;
         pmode_q <= '0;
         pv_q <= 1'b0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
         disp_q <= '0;
         done_q <= 1'b0;
         oflo_q <= 1'b0;
         sc_q <= '0;
         idx_q <= '0;
         bk_q <= '0;
         ph_q <= 1'b1;
         seg_q <= SEG_OFF;
         an_q <= AN_OFF;
      end else begin
         state_q <= state_d;
         val_q <= val_d;
         mode_q <= mode_d;
         pval_q <= pval_d;
         pmode_q <= pmode_d;
         pv_q <= pv_d;
         bcd_q <= bcd_d;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
         disp_q <= disp_d;
         done_q <= done_d;
         oflo_q <= oflo_d;
         sc_q <= sc_d;
         idx_q <= idx_d;
         bk_q <= bk_d;
         ph_q <= ph_d;
         seg_q <= seg_d;
         an_q <= an_d;
      end
   end

   assign dsp_io.seg = seg_q;
   assign dsp_io.an = an_q;
   assign dsp_io.busy = state_q != IDLE;
   assign dsp_io.done = done_q;
   assign dsp_io.overflow = oflo_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: randomized bench comparing scanned digits against a decimal reference model.
module tb_display_scan_driver;
   localparam int NA = 4, WA = 14, SA = 4, BA = 8;
   localparam int NB = 6, WB = 10, SB = 3, BB = 1000;

   logic clk = 1'b0;
   logic rst;
   int checks = 0, fails = 0;
   int dn_a = 0, dn_b = 0;
   logic [6:0] got [8];

   always #5 clk = ~clk;

   display_scan_if #(.NUM_DIGITS(NA), .VALUE_W(WA)) ifa ();
   display_scan_if #(.NUM_DIGITS(NB), .VALUE_W(WB)) ifb ();

   display_scan_driver #(.NUM_DIGITS(NA), .VALUE_W(WA), .SCAN_DIV(SA), .BLINK_DIV(BA),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
      dut_a (.clk(clk), .rst(rst), .dsp_io(ifa));
   display_scan_driver #(.NUM_DIGITS(NB), .VALUE_W(WB), .SCAN_DIV(SB), .BLINK_DIV(BB),
                         .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
      dut_b (.clk(clk), .rst(rst), .dsp_io(ifb));

   always @(negedge clk) begin
      if (ifa.done === 1'b1) dn_a++;
      if (ifb.done === 1'b1) dn_b++;
   end

   // Expected lit segments {g..a} of digit d for an n-digit panel showing value v in mode m
   function automatic logic [6:0] model(input int n, input int v, input int m, input int d);
      logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      logic [6:0] err [4] = '{7'h00, 7'h50, 7'h50, 7'h79};
      logic [6:0] dne [4] = '{7'h79, 7'h54, 7'h5C, 7'h5E};
      int lim = 1;
      int pw = 1;
      for (int i = 0; i < n; i++) lim *= 10;
      for (int i = 0; i < d; i++) pw *= 10;
      if (m == 3 || (m != 0 && d < n - 4)) return 7'h00;
      if (m == 1) return err[d - (n - 4)];
      if (m == 2) return dne[d - (n - 4)];
      if (v >= lim) return 7'h40;
      if (d > 0 && v < pw) return 7'h00;
      return lut[(v / pw) % 10];
   endfunction

   task automatic load(input bit b, input int v, input int m);
      if (b) begin
         ifb.value = WB'(v);
         ifb.mode = 2'(m);
         ifb.load = 1'b1;
      end else begin
         ifa.value = WA'(v);
         ifa.mode = 2'(m);
         ifa.load = 1'b1;
      end
      @(negedge clk);
      ifa.load = 1'b0;
      ifb.load = 1'b0;
   endtask

   task automatic wait_done(input bit b, output int k, output int nb);
      k = 0;
      nb = 0;
      while (k < 200 && (b ? ifb.done : ifa.done) !== 1'b1) begin
         if ((b ? ifb.busy : ifa.busy) === 1'b1) nb++;
         @(negedge clk);
         k++;
      end
   endtask

   task automatic capture(input bit b, input int cyc);
      logic [7:0] an_v;
      logic [6:0] sg;
      for (int d = 0; d < 8; d++) got[d] = 'x;
      repeat (cyc) begin
         @(negedge clk);
         an_v = b ? (8'(ifb.an) | 8'hC0) : (8'(ifa.an) | 8'hF0);
         sg = b ? ifb.seg : ifa.seg;
         for (int d = 0; d < 8; d++) if (an_v == ~(8'd1 << d)) got[d] = ~sg;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ifa.load = 1'b0; ifa.blink_en = 1'b0; ifa.value = '0; ifa.mode = 2'd0;
      ifb.load = 1'b0; ifb.blink_en = 1'b0; ifb.value = '0; ifb.mode = 2'd0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (ifa.seg !== 7'h7F || ifa.an !== 4'hF || ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_a seg=%b an=%b busy=%b done=%b ovf=%b expected 1111111 1111 0 0 0",
                  ifa.seg, ifa.an, ifa.busy, ifa.done, ifa.overflow);
      end
      checks++;
      if (ifb.seg !== 7'h7F || ifb.an !== 6'h3F || ifb.busy !== 1'b0 || ifb.overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_b seg=%b an=%b busy=%b ovf=%b expected 1111111 111111 0 0", ifb.seg, ifb.an, ifb.busy, ifb.overflow);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      capture(1'b0, NA * SA + 4);
      for (int d = 0; d < NA; d++) begin
         checks++;
         if (got[d] !== 7'h00) begin
            fails++;
            $display("FAIL reset_blank digit%0d got %h expected 00", d, got[d]);
         end
      end
   endtask

   task automatic test_latency();
      int k, nb;
      load(1'b0, 123, 0);
      wait_done(1'b0, k, nb);
      checks++;
      if (k != WA + 1) begin fails++; $display("FAIL done_latency got %0d expected %0d", k, WA + 1); end
      checks++;
      if (nb != WA + 1) begin fails++; $display("FAIL busy_cycles got %0d expected %0d", nb, WA + 1); end
      @(negedge clk);
      checks++;
      if (ifa.done !== 1'b0) begin fails++; $display("FAIL done_width got %b expected 0", ifa.done); end
      capture(1'b0, NA * SA + 4);
      for (int d = 0; d < NA; d++) begin
         checks++;
         if (got[d] !== model(NA, 123, 0, d)) begin
            fails++;
            $display("FAIL latency_digit%0d got %h expected %h", d, got[d], model(NA, 123, 0, d));
         end
      end
   endtask

   task automatic test_scan();
      logic [3:0] a0;
      int k, i0;
      a0 = ifa.an;
      k = 0;
      while (ifa.an === a0 && k < 20) begin @(negedge clk); k++; end
      i0 = 0;
      for (int d = 0; d < NA; d++) if (ifa.an === ~(4'd1 << d)) i0 = d;
      for (int j = 0; j < 4 * SA; j++) begin
         checks++;
         if (ifa.an !== ~(4'd1 << ((i0 + j / SA) % NA))) begin
            fails++;
            $display("FAIL scan_an cycle%0d got %b expected %b", j, ifa.an, ~(4'd1 << ((i0 + j / SA) % NA)));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_numeric();
      int vals [5] = '{7, 0, 255, 12345, 9999};
      int k, nb;
      foreach (vals[i]) begin
         load(1'b0, vals[i], 0);
         wait_done(1'b0, k, nb);
         checks++;
         if (ifa.overflow !== (vals[i] > 9999)) begin
            fails++;
            $display("FAIL numeric_ovf v=%0d got %b expected %b", vals[i], ifa.overflow, vals[i] > 9999);
         end
         capture(1'b0, NA * SA + 4);
         for (int d = 0; d < NA; d++) begin
            checks++;
            if (got[d] !== model(NA, vals[i], 0, d)) begin
               fails++;
               $display("FAIL numeric v=%0d digit%0d got %h expected %h", vals[i], d, got[d], model(NA, vals[i], 0, d));
            end
         end
      end
   endtask

   task automatic test_messages();
      int k, nb;
      load(1'b0, 16000, 0);
      wait_done(1'b0, k, nb);
      for (int m = 1; m < 4; m++) begin
         load(1'b0, int'($urandom_range(0, 16383)), m);
         wait_done(1'b0, k, nb);
         checks++;
         if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL msg_ovf mode=%0d got %b expected 0", m, ifa.overflow); end
         capture(1'b0, NA * SA + 4);
         for (int d = 0; d < NA; d++) begin
            checks++;
            if (got[d] !== model(NA, 0, m, d)) begin
               fails++;
               $display("FAIL msg mode=%0d digit%0d got %h expected %h", m, d, got[d], model(NA, 0, m, d));
            end
         end
      end
      load(1'b1, 5, 1);
      wait_done(1'b1, k, nb);
      capture(1'b1, NB * SB + 4);
      for (int d = 0; d < NB; d++) begin
         checks++;
         if (got[d] !== model(NB, 5, 1, d)) begin
            fails++;
            $display("FAIL msg6 digit%0d got %h expected %h", d, got[d], model(NB, 5, 1, d));
         end
      end
   endtask

   task automatic test_pending();
      int d0;
      d0 = dn_a;
      load(1'b0, 11, 0);
      @(negedge clk);
      load(1'b0, 22, 0);
      load(1'b0, 33, 0);
      repeat (3 * WA + 10) @(negedge clk);
      checks++;
      if (dn_a - d0 != 2) begin fails++; $display("FAIL pending_dones got %0d expected 2", dn_a - d0); end
      capture(1'b0, NA * SA + 4);
      for (int d = 0; d < NA; d++) begin
         checks++;
         if (got[d] !== model(NA, 33, 0, d)) begin
            fails++;
            $display("FAIL pending digit%0d got %h expected %h", d, got[d], model(NA, 33, 0, d));
         end
      end
   endtask

   task automatic test_commit_slot();
      int d0, v1, v2, v3;
      v1 = int'($urandom_range(0, 9999));
      v2 = int'($urandom_range(0, 9999));
      v3 = int'($urandom_range(0, 9999));
      d0 = dn_a;
      load(1'b0, v1, 0);
      @(negedge clk);
      load(1'b0, v2, 0);
      repeat (WA - 2) @(negedge clk);
      load(1'b0, v3, 0);
      repeat (3 * WA + 10) @(negedge clk);
      checks++;
      if (dn_a - d0 != 3) begin fails++; $display("FAIL commit_slot_dones got %0d expected 3", dn_a - d0); end
      capture(1'b0, NA * SA + 4);
      for (int d = 0; d < NA; d++) begin
         checks++;
         if (got[d] !== model(NA, v3, 0, d)) begin
            fails++;
            $display("FAIL commit_slot v=%0d digit%0d got %h expected %h", v3, d, got[d], model(NA, v3, 0, d));
         end
      end
   endtask

   task automatic test_random();
      int k, nb, v, m;
      for (int it = 0; it < 12; it++) begin
         bit b = it >= 8;
         int n = b ? NB : NA;
         v = b ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 16383));
         m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         load(b, v, m);
         wait_done(b, k, nb);
         checks++;
         if (k != (b ? WB : WA) + 1) begin fails++; $display("FAIL rand_latency got %0d expected %0d", k, (b ? WB : WA) + 1); end
         checks++;
         if ((b ? ifb.overflow : ifa.overflow) !== (m == 0 && !b && v > 9999)) begin
            fails++;
            $display("FAIL rand_ovf v=%0d m=%0d got %b", v, m, b ? ifb.overflow : ifa.overflow);
         end
         capture(b, b ? NB * SB + 4 : NA * SA + 4);
         for (int d = 0; d < n; d++) begin
            checks++;
            if (got[d] !== model(n, v, m, d)) begin
               fails++;
               $display("FAIL rand n=%0d v=%0d m=%0d digit%0d got %h expected %h", n, v, m, d, got[d], model(n, v, m, d));
            end
         end
      end
   endtask

   task automatic test_blink();
      int k;
      bit lit_prev;
      ifa.blink_en = 1'b1;
      repeat (2) @(negedge clk);
      k = 0;
      lit_prev = 1'b0;
      while (k < 40 && !(lit_prev && ifa.an === 4'hF)) begin
         lit_prev = ifa.an !== 4'hF;
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 40) begin fails++; $display("FAIL blink_edge got no dark phase within %0d cycles expected one", k); end
      for (int j = 0; j < 3 * BA; j++) begin
         checks++;
         if ((j / BA) % 2 == 0 ? (ifa.an !== 4'hF || ifa.seg !== 7'h7F) : (ifa.an === 4'hF)) begin
            fails++;
            $display("FAIL blink cycle%0d an=%b seg=%b expected dark=%0d", j, ifa.an, ifa.seg, (j / BA) % 2 == 0);
         end
         @(negedge clk);
      end
      ifa.blink_en = 1'b0;
   endtask

   task automatic test_reset_midconv();
      int k, nb, d0;
      load(1'b0, 12345, 0);
      wait_done(1'b0, k, nb);
      load(1'b0, 500, 0);
      repeat (3) @(negedge clk);
      d0 = dn_a;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.overflow !== 1'b0 || ifa.an !== 4'hF || ifa.seg !== 7'h7F) begin
         fails++;
         $display("FAIL midconv_reset busy=%b done=%b ovf=%b an=%b seg=%b expected 0 0 0 1111 1111111",
                  ifa.busy, ifa.done, ifa.overflow, ifa.an, ifa.seg);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (WA + 8) @(negedge clk);
      checks++;
      if (dn_a != d0) begin fails++; $display("FAIL midconv_done got %0d pulses expected 0", dn_a - d0); end
      capture(1'b0, NA * SA + 4);
      for (int d = 0; d < NA; d++) begin
         checks++;
         if (got[d] !== 7'h00) begin fails++; $display("FAIL midconv_blank digit%0d got %h expected 00", d, got[d]); end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_scan();
      test_numeric();
      test_messages();
      test_pending();
      test_commit_slot();
      test_random();
      test_blink();
      test_reset_midconv();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, expected completion before 500000");
      $fatal(1);
   end
endmodule
